// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared constants for the OCXO tuning PWM. The PWM generator and its duty
// controller both import these values so that they agree on period and duty.
package pwm_duty_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int unsigned PERIOD_DEF         = 65535;
  localparam int unsigned DUTY_MIN_DEF       = 1;
  localparam int unsigned DUTY_MAX_DEF       = 65534;
  localparam int unsigned DUTY_INIT_DEF      = 32768;
  localparam int unsigned MAX_STEP_DEF       = 256;
  localparam int unsigned WARMUP_PERIODS_DEF = 16;

  function automatic logic [31:0] clamp_duty(input logic [31:0] val,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    logic [31:0] res;
    res = val;
    if (val < lo) res = lo;
    else if (val > hi) res = hi;
    return res;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_duty_slew.sv
// Combinational request clamp and per-period step limiter for the applied duty.
module pwm_duty_ctrl_duty_slew
  import pwm_duty_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_MIN = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic [31:0] duty,
  input  logic [31:0] target,
  input  logic [31:0] max_step,
  input  logic [31:0] req,
  output logic [31:0] duty_next,
  output logic [31:0] req_clamped
);

  logic [31:0] diff;
  logic [31:0] step;

  // Operands always sit inside [DUTY_MIN, DUTY_MAX], so the subtraction cannot wrap.
  always_comb begin
    diff      = 32'd0;
    step      = 32'd0;
    duty_next = duty;
    if (target > duty) begin
      diff      = target - duty;
      step      = (diff > max_step) ? max_step : diff;
      duty_next = duty + step;
    end else if (duty > target) begin
      diff      = duty - target;
      step      = (diff > max_step) ? max_step : diff;
      duty_next = duty - step;
    end
  end

  assign req_clamped = clamp_duty(req, 32'(DUTY_MIN), 32'(DUTY_MAX));

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Sequencer and duty update scheduler for the OCXO tuning PWM: warm-up at a
// preset duty, then slew-limited tracking of loop filter requests at period edges.
//
// state  | meaning
// IDLE   | PWM disabled, duty parked at DUTY_INIT
// WARMUP | PWM running at DUTY_INIT for WARMUP_PERIODS full periods
// RUN    | requests accepted, duty slews toward target once per period
// HOLD   | holdover, duty frozen, target retained
module pwm_duty_ctrl
  import pwm_duty_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD         = PERIOD_DEF,
  parameter int unsigned DUTY_MIN       = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX       = DUTY_MAX_DEF,
  parameter int unsigned DUTY_INIT      = DUTY_INIT_DEF,
  parameter int unsigned MAX_STEP       = MAX_STEP_DEF,
  parameter int unsigned WARMUP_PERIODS = WARMUP_PERIODS_DEF
) (
  input  logic        Clk_Sys,
  input  logic        Clk_Rst,
  input  logic        Ctrl_Start,
  input  logic        Ctrl_Stop,
  input  logic        Hold,
  input  logic        Req_Valid,
  input  logic [31:0] Req_Duty,
  output logic        Req_Ready,
  output logic        PWM_En,
  output logic [31:0] PWM_Duty,
  output logic        Period_Tick,
  output logic        Slewing,
  output logic [1:0]  State
);

  localparam logic [16:0] CNT_LAST  = 17'(PERIOD - 1);
  localparam logic [16:0] CNT_PRE   = 17'(PERIOD - 2);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_PERIODS - 1);
  localparam logic [31:0] INIT_DUTY = 32'(DUTY_INIT);

  state_e      state;
  state_e      state_next;
  logic [16:0] period_cnt;
  logic [15:0] warm_cnt;
  logic [31:0] duty;
  logic [31:0] target;
  logic [31:0] duty_nxt;
  logic [31:0] target_nxt;
  logic [31:0] duty_stepped;
  logic [31:0] req_clamped;
  logic        accept;
  logic        warm_done;

  pwm_duty_ctrl_duty_slew #(
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX)
  ) u_duty_slew (
    .duty        (duty),
    .target      (target),
    .max_step    (32'(MAX_STEP)),
    .req         (Req_Duty),
    .duty_next   (duty_stepped),
    .req_clamped (req_clamped)
  );

  assign PWM_En    = (state != ST_IDLE);
  assign Req_Ready = (state == ST_RUN) && !Hold && !Ctrl_Stop;
  assign accept    = Req_Valid && Req_Ready;
  assign warm_done = Period_Tick && (warm_cnt == WARM_LAST);
  assign PWM_Duty  = duty;
  assign State     = state;

  always_ff @(posedge Clk_Sys) begin
    if (Clk_Rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (Ctrl_Stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (Ctrl_Start) state_next = ST_WARMUP;
        ST_WARMUP: if (warm_done)  state_next = ST_RUN;
        ST_RUN:    if (Hold)       state_next = ST_HOLD;
        ST_HOLD:   if (!Hold)      state_next = ST_RUN;
        default:                   state_next = ST_IDLE;
      endcase
    end
  end

  // Tick is registered one count early so it is high exactly while the counter sits at PERIOD-1.
  always_ff @(posedge Clk_Sys) begin
    if (Clk_Rst || Ctrl_Stop || !PWM_En) begin
      period_cnt  <= 17'd0;
      Period_Tick <= 1'b0;
    end else begin
      period_cnt  <= (period_cnt == CNT_LAST) ? 17'd0 : period_cnt + 17'd1;
      Period_Tick <= (period_cnt == CNT_PRE);
    end
  end

  always_ff @(posedge Clk_Sys) begin
    if (Clk_Rst || Ctrl_Stop || (state != ST_WARMUP)) warm_cnt <= 16'd0;
    else if (Period_Tick)                             warm_cnt <= warm_cnt + 16'd1;
  end

  // A same-cycle accept only moves the target; the step in that cycle still uses the old one.
  always_comb begin
    duty_nxt   = duty;
    target_nxt = target;
    if (Ctrl_Stop) begin
      duty_nxt   = INIT_DUTY;
      target_nxt = INIT_DUTY;
    end else begin
      if ((state == ST_RUN) && !Hold && Period_Tick) duty_nxt = duty_stepped;
      if (accept) target_nxt = req_clamped;
    end
  end

  always_ff @(posedge Clk_Sys) begin
    if (Clk_Rst) begin
      duty    <= INIT_DUTY;
      target  <= INIT_DUTY;
      Slewing <= 1'b0;
    end else begin
      duty    <= duty_nxt;
      target  <= target_nxt;
      Slewing <= (duty_nxt != target_nxt);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with a short 16-clock period and 2 warm-up periods.
module tb_pwm_duty_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_duty = 32'd0;
  logic        req_ready;
  logic        pwm_en;
  logic [31:0] pwm_duty;
  logic        period_tick;
  logic        slewing;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int k;
  int exp_seq[3] = '{33512, 33768, 34000};

  always #5 clk = ~clk;

  pwm_duty_ctrl #(
    .PERIOD         (16),
    .WARMUP_PERIODS (2)
  ) dut (
    .Clk_Sys     (clk),
    .Clk_Rst     (rst),
    .Ctrl_Start  (start),
    .Ctrl_Stop   (stop),
    .Hold        (hold),
    .Req_Valid   (req_valid),
    .Req_Duty    (req_duty),
    .Req_Ready   (req_ready),
    .PWM_En      (pwm_en),
    .PWM_Duty    (pwm_duty),
    .Period_Tick (period_tick),
    .Slewing     (slewing),
    .State       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!period_tick && cycles < 64);
    if (!period_tick) chk("tick_timeout", {31'd0, period_tick}, 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_duty  = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic slew_until(input logic [31:0] goal, output int ticks);
    int c;
    ticks = 0;
    do begin
      wait_tick(c);
      @(negedge clk);
      ticks++;
    end while (pwm_duty != goal && ticks < 300);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_en", pwm_en, 0);
    chk("rst_duty", pwm_duty, 32768);
    chk("rst_ready", req_ready, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_slewing", slewing, 0);
    rst = 1'b0;

    start = 1'b1;
    stop  = 1'b1;
    repeat (2) @(negedge clk);
    chk("startstop_state", state, 0);
    chk("startstop_en", pwm_en, 0);

    stop = 1'b0;
    @(negedge clk);
    chk("warm_state", state, 1);
    chk("warm_en", pwm_en, 1);
    chk("warm_ready", req_ready, 0);
    wait_tick(n);
    chk("first_tick_gap", n, 15);

    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_warm_state", state, 0);
    chk("stop_warm_en", pwm_en, 0);
    chk("stop_warm_tick", period_tick, 0);
    stop = 1'b0;
    @(negedge clk);
    chk("restart_state", state, 1);
    wait_tick(n);
    chk("restart_tick_gap", n, 15);
    wait_tick(n);
    chk("warm_tick_gap", n, 16);
    chk("warm_still_warmup", state, 1);
    chk("warm_duty", pwm_duty, 32768);
    @(negedge clk);
    chk("run_state", state, 2);
    chk("run_duty", pwm_duty, 32768);
    chk("run_ready", req_ready, 1);

    send(33000);
    chk("req1_slewing", slewing, 1);
    chk("req1_duty_wait", pwm_duty, 32768);
    wait_tick(n);
    @(negedge clk);
    chk("req1_duty", pwm_duty, 33000);
    chk("req1_settled", slewing, 0);

    send(34000);
    wait_tick(n);
    @(negedge clk);
    chk("req2_step1", pwm_duty, 33256);
    chk("req2_slewing", slewing, 1);

    hold = 1'b1;
    @(negedge clk);
    chk("hold_state", state, 3);
    chk("hold_ready", req_ready, 0);
    chk("hold_en", pwm_en, 1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      chk("hold_duty", pwm_duty, 33256);
    end
    wait_tick(n);
    chk("hold_tick_gap", n, 16);
    @(negedge clk);
    chk("hold_duty_after", pwm_duty, 33256);
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_state", state, 2);
    chk("unhold_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      @(negedge clk);
      chk("resume_step", pwm_duty, exp_seq[i]);
    end
    chk("resume_settled", slewing, 0);

    send(0);
    chk("clamp_lo_slewing", slewing, 1);
    slew_until(32'd1, k);
    chk("clamp_lo_ticks", k, 133);
    chk("clamp_lo_duty", pwm_duty, 1);
    chk("clamp_lo_settled", slewing, 0);

    send(70000);
    slew_until(32'd65534, k);
    chk("clamp_hi_ticks", k, 256);
    chk("clamp_hi_duty", pwm_duty, 65534);
    chk("clamp_hi_settled", slewing, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_duty  = 32'd50000;
    @(negedge clk);
    req_duty  = 32'd40000;
    @(negedge clk);
    req_valid = 1'b0;
    slew_until(32'd40000, k);
    chk("overwrite_ticks", k, 100);
    chk("overwrite_duty", pwm_duty, 40000);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_state", state, 0);
    chk("midrun_rst_en", pwm_en, 0);
    chk("midrun_rst_duty", pwm_duty, 32768);
    chk("midrun_rst_ready", req_ready, 0);
    chk("midrun_rst_slewing", slewing, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Sequencer and update scheduler for the OCXO tuning PWM. It owns PWM_En and PWM_Duty of the PWM generator. It brings the PWM up at a preset duty and holds it there through a warm-up interval. It then accepts duty requests from the loop filter over a valid/ready handshake, clamps them, and slews the applied duty toward the target. Duty changes happen only at PWM period boundaries, which keeps the control voltage glitch-free.

Parameters:
PERIOD, 65535, PWM period in Clk_Sys cycles; must equal the PWM generator's pulse constant
DUTY_MIN, 1, lowest applied duty; must be >= 1
DUTY_MAX, 65534, highest applied duty; must be <= PERIOD-1
DUTY_INIT, 32768, duty applied at reset, during warm-up and after stop
MAX_STEP, 256, largest change to the applied duty per PWM period
WARMUP_PERIODS, 16, number of full PWM periods spent in WARMUP before RUN

Ports:
Clk_Sys  in  1  system clock
Clk_Rst  in  1  synchronous reset, active-high
Ctrl_Start  in  1  level; leave IDLE and begin warm-up
Ctrl_Stop  in  1  level; return to IDLE; takes priority over all other inputs
Hold  in  1  level; holdover mode, freezes the applied duty
Req_Valid  in  1  duty request valid
Req_Duty  in  32  requested duty in clocks (unsigned)
Req_Ready  out  1  request accepted when Req_Valid && Req_Ready
PWM_En  out  1  drives the PWM generator enable
PWM_Duty  out  32  drives the PWM generator duty
Period_Tick  out  1  one-cycle pulse on the last clock of each PWM period
Slewing  out  1  applied duty != target
State  out  2  0=IDLE 1=WARMUP 2=RUN 3=HOLD

Behaviour:
- Reset (Clk_Rst=1 at a Clk_Sys edge), from any state including mid-slew:
  - State=IDLE, PWM_En=0, PWM_Duty=DUTY_INIT, target=DUTY_INIT.
  - Req_Ready=0, Period_Tick=0, Slewing=0; period and warm-up counters cleared.
- Period counter (17-bit), mirrors the PWM generator's counter:
  - Counts 0..PERIOD-1 while PWM_En=1; held at 0 while PWM_En=0.
  - Period_Tick is registered and high for the cycle in which the counter equals PERIOD-1.
- IDLE:
  - PWM_En=0.
  - Ctrl_Start=1 && Ctrl_Stop=0 -> WARMUP; PWM_En=1 from the next cycle.
- WARMUP:
  - PWM_Duty held at DUTY_INIT.
  - Each Period_Tick increments the warm-up counter; on the WARMUP_PERIODS-th tick -> RUN.
  - Requests are not accepted (Req_Ready=0).
- RUN:
  - Req_Ready = 1 (combinational from state, Hold and Ctrl_Stop: RUN && !Hold && !Ctrl_Stop).
  - On accept, target <= clamp(Req_Duty, DUTY_MIN, DUTY_MAX) using an unsigned 32-bit compare. A newer accept overwrites a pending target.
  - On each Period_Tick:
    - If PWM_Duty < target: PWM_Duty += min(MAX_STEP, target-PWM_Duty).
    - If PWM_Duty > target: PWM_Duty -= min(MAX_STEP, PWM_Duty-target).
    - The new PWM_Duty takes effect at counter 0 of the next period.
  - Accept and Period_Tick in the same cycle: the step uses the old target; the new target is used from the next tick onward.
  - Hold=1 -> HOLD.
- HOLD:
  - PWM_Duty frozen, PWM_En stays 1, Req_Ready=0.
  - Target retained; Period_Tick keeps pulsing.
  - Hold=0 -> RUN; slewing resumes at the next tick.
- Ctrl_Stop=1 in any state:
  - Next state is IDLE; PWM_En=0, PWM_Duty=DUTY_INIT, target=DUTY_INIT.
  - Period and warm-up counters cleared.
  - Ctrl_Start and Ctrl_Stop both high resolves as stop.
- Slewing = (PWM_Duty != target), registered.
- Arithmetic: duty and target are 32-bit unsigned; differences are computed on 32 bits with no wrap, since both operands always lie in [DUTY_MIN, DUTY_MAX].

Decomposition:
- Shared package: state encoding constants (IDLE/WARMUP/RUN/HOLD), the PERIOD default, and DUTY_MIN/DUTY_MAX/DUTY_INIT defaults, so the PWM generator and this block cannot diverge.
- One natural sub-module: duty_slew, a combinational clamp plus step limiter taking current duty, target and MAX_STEP and returning the next duty. The FSM, counters and handshake stay at top level.

Test Plan:
- Reset mid-RUN with PWM_Duty=40000 -> next cycle State=0, PWM_En=0, PWM_Duty=32768, Req_Ready=0.
- Start with WARMUP_PERIODS=2 and PERIOD=16 -> PWM_En=1; Period_Tick every 16 clocks; State=2 after the 2nd tick; duty stays 32768 throughout.
- RUN, request 33000 (MAX_STEP=256) -> duty sequence 33024? no: 32768->33000 in one step (232 <= 256), then Slewing=0; request 34000 -> 33256, 33512, 33768, 34000 on four successive ticks.
- Request 0 then 70000 -> target clamps to 1 and then to 65534; duty moves by 256 per tick; Slewing=1 until equal.
- Hold asserted while slewing at duty 33256 -> duty frozen across 3 ticks, Req_Ready=0; release -> 33512 at the next tick.
- Ctrl_Start=Ctrl_Stop=1 in IDLE -> stays IDLE; Ctrl_Stop in WARMUP -> IDLE next cycle, counters zero.
